reg_ser_bridge: RTL and testbench

//  Serial host-to-register bridge that sits directly upstream of my_reg.
//  It deserialises bit-strobed host frames into single-cycle register write/read strobes.
//  It returns read data serially. The DFT scan ports follow the same scan-port set as my_reg.

---
 rtl/reg_ser_bridge.sv | 166 ++++++++++++++++
 tb/tb_reg_ser_bridge.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_ser_bridge.sv
// reg_ser_bridge: turns bit-strobed host frames (R/W, address, data; MSB first)
// into single-cycle register write/read strobes and shifts read data back out.
// Every flop is packed into one struct so that scan mode can chain them all
// from scan_in0 to scan_out0 without listing each register twice.
module reg_ser_bridge #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ser_cs_n,
   input  logic              ser_bit_vld,
   input  logic              ser_di,
   output logic              ser_do,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              reg_wr_en,
   output logic              reg_rd_en,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic              frame_err,
   input  logic              scan_in0,
   input  logic              scan_en,
   input  logic              test_mode,
   output logic              scan_out0
);

   localparam int F     = 1 + ADDR_W + DATA_W;
   localparam int CNT_W = $clog2(F + 1);
   localparam int SH_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

   localparam logic [CNT_W-1:0] CNT_ADDR_END = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(F - 1);
   localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(F);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      RDREQ = 3'd2,
      RDATA = 3'd3,
      WDATA = 3'd4,
      DONE  = 3'd5
   } state_e;

   // The shift register collects address bits, then either write data bits or
   // holds the read data being returned; it is wide enough for either field.
   typedef struct packed {
      state_e            state;
      logic              isRead;
      logic [CNT_W-1:0]  bitCnt;
      logic              csPrev;
      logic [SH_W-1:0]   shiftReg;
      logic [ADDR_W-1:0] regAddr;
      logic [DATA_W-1:0] regWdata;
      logic              wrEn;
      logic              rdEn;
      logic              frameErr;
   } regs_t;

   localparam int SCAN_W = $bits(regs_t);

   regs_t             r_q;
   logic [SCAN_W-1:0] flat;
   logic [SCAN_W-1:0] scan_d;
   logic              scanShift;
   logic              sample;
   logic              csRise;

   assign flat      = r_q;
   assign scan_d    = {flat[SCAN_W-2:0], scan_in0};
   assign scanShift = test_mode & scan_en;
   assign sample    = ser_bit_vld & ~ser_cs_n;
   assign csRise    = ser_cs_n & ~r_q.csPrev;

   // Frame FSM: counts sampled bits, latches address/data and issues strobes;
   // in scan shift mode every flop instead moves one place along the chain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_q <= '0;
      end else if (scanShift) begin
         r_q <= regs_t'(scan_d);
      end else begin
         r_q.wrEn     <= 1'b0;
         r_q.rdEn     <= 1'b0;
         r_q.frameErr <= 1'b0;
         r_q.csPrev   <= ser_cs_n;
         if (csRise) begin
            if (r_q.bitCnt != '0) begin
               if (r_q.bitCnt != CNT_FULL) begin
                  r_q.frameErr <= 1'b1;
               end
               r_q.state  <= IDLE;
               r_q.bitCnt <= '0;
            end
         end else begin
            case (r_q.state)
               IDLE: begin
                  if (sample) begin
                     r_q.isRead <= ser_di;
                     r_q.bitCnt <= CNT_ONE;
                     r_q.state  <= ADDR;
                  end
               end
               ADDR: begin
                  if (sample) begin
                     r_q.bitCnt   <= r_q.bitCnt + CNT_ONE;
                     r_q.shiftReg <= {r_q.shiftReg[SH_W-2:0], ser_di};
                     if (r_q.bitCnt == CNT_ADDR_END) begin
                        r_q.regAddr <= {r_q.shiftReg[ADDR_W-2:0], ser_di};
                        if (r_q.isRead) begin
                           r_q.rdEn  <= 1'b1;
                           r_q.state <= RDREQ;
                        end else begin
                           r_q.state <= WDATA;
                        end
                     end
                  end
               end
               RDREQ: begin
                  r_q.shiftReg <= SH_W'(reg_rdata);
                  r_q.state    <= RDATA;
                  if (sample) begin
                     r_q.bitCnt <= r_q.bitCnt + CNT_ONE;
                  end
               end
               RDATA: begin
                  if (sample) begin
                     r_q.bitCnt   <= r_q.bitCnt + CNT_ONE;
                     r_q.shiftReg <= {r_q.shiftReg[SH_W-2:0], 1'b0};
                     if (r_q.bitCnt == CNT_LAST) begin
                        r_q.state <= DONE;
                     end
                  end
               end
               WDATA: begin
                  if (sample) begin
                     r_q.bitCnt   <= r_q.bitCnt + CNT_ONE;
                     r_q.shiftReg <= {r_q.shiftReg[SH_W-2:0], ser_di};
                     if (r_q.bitCnt == CNT_LAST) begin
                        r_q.regWdata <= {r_q.shiftReg[DATA_W-2:0], ser_di};
                        r_q.wrEn     <= 1'b1;
                        r_q.state    <= DONE;
                     end
                  end
               end
               DONE: begin
                  r_q.state <= DONE;
               end
               default: begin
                  r_q.state  <= IDLE;
                  r_q.bitCnt <= '0;
               end
            endcase
         end
      end
   end

   assign ser_do    = (r_q.state == RDATA) & r_q.shiftReg[DATA_W-1];
   assign reg_addr  = r_q.regAddr;
   assign reg_wdata = r_q.regWdata;
   assign reg_wr_en = r_q.wrEn & ~scanShift;
   assign reg_rd_en = r_q.rdEn & ~scanShift;
   assign frame_err = r_q.frameErr & ~scanShift;
   assign scan_out0 = test_mode & flat[SCAN_W-1];

endmodule

// File: tb/tb_reg_ser_bridge.sv
// tb_reg_ser_bridge: directed frames for reg_ser_bridge. Stimulus pushes the
// expected register events and read-back bits into queues; a monitor pops and
// compares them whenever the bridge presents a strobe or a bit is clocked.
module tb_reg_ser_bridge;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;
   localparam logic [1:0] EV_WR  = 2'd1;
   localparam logic [1:0] EV_RD  = 2'd2;
   localparam logic [1:0] EV_ERR = 2'd3;

   typedef struct packed {
      logic [1:0] kind;
      logic [6:0] addr;
      logic [7:0] data;
   } ev_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              ser_cs_n;
   logic              ser_bit_vld;
   logic              ser_di;
   logic              ser_do;
   logic [ADDR_W-1:0] reg_addr;
   logic [DATA_W-1:0] reg_wdata;
   logic              reg_wr_en;
   logic              reg_rd_en;
   logic [DATA_W-1:0] reg_rdata;
   logic              frame_err;
   logic              scan_in0;
   logic              scan_en;
   logic              test_mode;
   logic              scan_out0;

   logic              chkDo = 1'b0;
   ev_t               expQ[$];
   logic              doQ[$];
   int                assertCnt = 0;
   int                failCnt = 0;

   reg_ser_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk),
      .reset(reset),
      .ser_cs_n(ser_cs_n),
      .ser_bit_vld(ser_bit_vld),
      .ser_di(ser_di),
      .ser_do(ser_do),
      .reg_addr(reg_addr),
      .reg_wdata(reg_wdata),
      .reg_wr_en(reg_wr_en),
      .reg_rd_en(reg_rd_en),
      .reg_rdata(reg_rdata),
      .frame_err(frame_err),
      .scan_in0(scan_in0),
      .scan_en(scan_en),
      .test_mode(test_mode),
      .scan_out0(scan_out0)
   );

   // Free-running 100 MHz clock
   initial forever #5 clk = ~clk;

   // Hard stop in case anything stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertCnt++;
      if (act !== exp) begin
         failCnt++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pushEv(input logic [1:0] kind, input logic [6:0] addr, input logic [7:0] data);
      expQ.push_back({kind, addr, data});
   endtask

   task automatic checkEvent(input logic [1:0] kind, input logic [6:0] addr, input logic [7:0] data);
      ev_t got;
      ev_t exp;
      got = {kind, addr, data};
      if (expQ.size() == 0) begin
         assertCnt++;
         failCnt++;
         $display("[TB] FAIL unexpected_event: got 0x%0h, required no event at %0t", got, $time);
      end else begin
         exp = expQ.pop_front();
         checkOutput("event", 32'(got), 32'(exp));
      end
   endtask

   // One strobed bit followed by an idle cycle, so strobes are two clocks apart
   task automatic sendBit(input logic b, input logic doChk, input logic doExp);
      @(posedge clk);
      #2;
      ser_bit_vld = 1'b1;
      ser_di      = b;
      chkDo       = doChk;
      if (doChk) doQ.push_back(doExp);
      @(posedge clk);
      #2;
      ser_bit_vld = 1'b0;
      chkDo       = 1'b0;
   endtask

   // Sends nBits of frame, first bit = frame[nBits-1]; data-phase bits of a read
   // expect ser_do to replay rdExp MSB first. Optionally closes the frame.
   task automatic applyStimulus(input logic [31:0] frame, input int nBits, input logic isRead,
                                input logic [7:0] rdExp, input logic raise);
      int   bitNum;
      logic dc;
      logic de;
      @(posedge clk);
      #2 ser_cs_n = 1'b0;
      for (int i = 0; i < nBits; i++) begin
         bitNum = i + 1;
         dc     = isRead && (bitNum >= 9) && (bitNum <= 16);
         de     = 1'b0;
         if (dc) de = rdExp[16 - bitNum];
         sendBit(frame[nBits - 1 - i], dc, de);
      end
      if (raise) begin
         @(posedge clk);
         #2 ser_cs_n = 1'b1;
         repeat (3) @(posedge clk);
      end
   endtask

   // Monitor: compares every strobe against the expected-event queue and every
   // clocked bit's ser_do against the read-back queue (or zero outside reads)
   always @(negedge clk) begin
      if (reset) begin
         if (reg_wr_en) checkEvent(EV_WR, reg_addr, reg_wdata);
         if (reg_rd_en) checkEvent(EV_RD, reg_addr, 8'h00);
         if (frame_err) checkEvent(EV_ERR, 7'h00, 8'h00);
         if (ser_bit_vld) begin
            if (chkDo) begin
               if (doQ.size() == 0) begin
                  assertCnt++;
                  failCnt++;
                  $display("[TB] FAIL ser_do_queue: got empty queue, required an entry");
               end else begin
                  checkOutput("ser_do_read", 32'(ser_do), 32'(doQ.pop_front()));
               end
            end else begin
               checkOutput("ser_do_idle", 32'(ser_do), 32'd0);
            end
         end
      end
   end

   // Directed test sequence
   initial begin
      logic [15:0] pat;
      logic        obs [220];
      int          lat;
      reset       = 1'b0;
      ser_cs_n    = 1'b1;
      ser_bit_vld = 1'b0;
      ser_di      = 1'b0;
      reg_rdata   = 8'h00;
      scan_in0    = 1'b0;
      scan_en     = 1'b0;
      test_mode   = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_ser_do", 32'(ser_do), 0);
      checkOutput("rst_reg_addr", 32'(reg_addr), 0);
      checkOutput("rst_reg_wdata", 32'(reg_wdata), 0);
      checkOutput("rst_strobes", 32'({reg_wr_en, reg_rd_en, frame_err}), 0);
      checkOutput("rst_scan_out", 32'(scan_out0), 0);
      @(posedge clk);
      #2 reset = 1'b1;
      repeat (2) @(posedge clk);

      $display("[TB] write frame addr 0x05 data 0xA5");
      pushEv(EV_WR, 7'h05, 8'hA5);
      applyStimulus(32'h05A5, 16, 1'b0, 8'h00, 1'b1);
      #1;
      checkOutput("hold_addr", 32'(reg_addr), 32'h05);
      checkOutput("hold_wdata", 32'(reg_wdata), 32'hA5);

      $display("[TB] read frame addr 0x13 rdata 0x3C");
      reg_rdata = 8'h3C;
      pushEv(EV_RD, 7'h13, 8'h00);
      applyStimulus(32'h93FF, 16, 1'b1, 8'h3C, 1'b1);

      $display("[TB] frame aborted after 10 bits, then full write");
      pushEv(EV_ERR, 7'h00, 8'h00);
      applyStimulus(32'h016, 10, 1'b0, 8'h00, 1'b1);
      pushEv(EV_WR, 7'h2A, 8'h5C);
      applyStimulus(32'h2A5C, 16, 1'b0, 8'h00, 1'b1);

      $display("[TB] read aborted inside data phase");
      pushEv(EV_RD, 7'h01, 8'h00);
      pushEv(EV_ERR, 7'h00, 8'h00);
      applyStimulus(32'h81F, 12, 1'b1, 8'h3C, 1'b1);

      $display("[TB] write frame with 20 strobes");
      pushEv(EV_WR, 7'h7F, 8'h81);
      applyStimulus(32'h7F81A, 20, 1'b0, 8'h00, 1'b1);

      $display("[TB] reset after 12 bits of a write");
      applyStimulus(32'h33F, 12, 1'b0, 8'h00, 1'b0);
      checkOutput("mid_addr", 32'(reg_addr), 32'h33);
      checkOutput("mid_wdata_hold", 32'(reg_wdata), 32'h81);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      checkOutput("rst_mid_addr", 32'(reg_addr), 0);
      checkOutput("rst_mid_wdata", 32'(reg_wdata), 0);
      checkOutput("rst_mid_strobes", 32'({reg_wr_en, reg_rd_en, frame_err, ser_do}), 0);
      ser_cs_n = 1'b1;
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      repeat (2) @(posedge clk);
      reg_rdata = 8'hC3;
      pushEv(EV_RD, 7'h55, 8'h00);
      applyStimulus(32'hD500, 16, 1'b1, 8'hC3, 1'b1);

      $display("[TB] scan chain shift");
      @(posedge clk);
      #2;
      test_mode = 1'b1;
      scan_en   = 1'b1;
      scan_in0  = 1'b1;
      repeat (100) @(posedge clk);
      #3;
      checkOutput("scan_fill_ones", 32'(scan_out0), 1);
      checkOutput("scan_fill_strobes", 32'({reg_wr_en, reg_rd_en, frame_err}), 0);
      test_mode = 1'b0;
      #1;
      checkOutput("scan_out_tm0", 32'(scan_out0), 0);
      test_mode = 1'b1;
      pat = 16'hB38D;
      for (int c = 0; c < 220; c++) begin
         @(posedge clk);
         #2;
         if (c >= 100 && c < 116) scan_in0 = pat[15 - (c - 100)];
         else scan_in0 = 1'b0;
         @(negedge clk);
         obs[c] = scan_out0;
         checkOutput("scan_strobes", 32'({reg_wr_en, reg_rd_en, frame_err}), 0);
      end
      checkOutput("scan_flushed", 32'(obs[100]), 0);
      lat = -1;
      for (int c = 101; c < 204; c++) begin
         if (lat < 0 && obs[c] == 1'b1) lat = c;
      end
      if (lat < 0) begin
         assertCnt++;
         failCnt++;
         $display("[TB] FAIL scan_latency: got no pattern on scan_out0, required pattern within 100 cycles");
      end else begin
         for (int k = 0; k < 16; k++) begin
            checkOutput("scan_pattern", 32'(obs[lat + k]), 32'(pat[15 - k]));
         end
      end

      @(posedge clk);
      #2;
      reset     = 1'b0;
      scan_en   = 1'b0;
      test_mode = 1'b0;
      scan_in0  = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      repeat (2) @(posedge clk);
      pushEv(EV_WR, 7'h05, 8'hA5);
      applyStimulus(32'h05A5, 16, 1'b0, 8'h00, 1'b1);

      repeat (4) @(posedge clk);
      #1;
      checkOutput("events_pending", 32'(expQ.size()), 0);
      checkOutput("ser_do_pending", 32'(doQ.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
      $finish;
   end

endmodule
